stream_pack_unpack: RTL and testbench



---
 rtl/spatial_filter_pkg.sv | 21 ++
 rtl/stream_pack_core.sv | 100 ++++++++++
 rtl/stream_unpack_core.sv | 94 +++++++++
 rtl/stream_pack_unpack.sv | 80 ++++++++
 tb/tb_stream_pack_unpack.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spatial_filter_pkg.sv
// Shared constants and helpers for the spatial-filter pixel path.
// Used by the legacy pack/unpack macros and the stream converter.
package spatial_filter_pkg;

    localparam int MODE_PACK   = 0;
    localparam int MODE_UNPACK = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int lane_lsb(input int idx, input int elem_w);
        return idx * elem_w;
    endfunction

endpackage

// File: rtl/stream_pack_core.sv
// Gathers NUM_ELEM narrow elements into one wide word, lane 0 first.
// Partial words close on in_last; unfilled lanes stay zero.
module stream_pack_core
    import spatial_filter_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int NUM_ELEM = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEM_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ELEM_W*NUM_ELEM-1:0]   out_data,
    output logic [NUM_ELEM-1:0]          out_keep,
    output logic                         out_last
);

    localparam int CNT_W = clog2(NUM_ELEM);
    localparam int OUT_W = ELEM_W * NUM_ELEM;

    logic [CNT_W-1:0]    r_idx;
    logic [OUT_W-1:0]    r_acc;
    logic [NUM_ELEM-1:0] r_acc_keep;
    logic [OUT_W-1:0]    r_out_data;
    logic [NUM_ELEM-1:0] r_out_keep;
    logic                r_out_last;
    logic                r_out_valid;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_done;
    logic [OUT_W-1:0]    w_acc_next;
    logic [NUM_ELEM-1:0] w_keep_next;

    assign in_ready   = !r_out_valid | out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_done     = w_in_fire &
                        ((r_idx == CNT_W'(NUM_ELEM - 1)) | in_last);

    always_comb begin
        w_acc_next  = r_acc;
        w_keep_next = r_acc_keep;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (r_idx == CNT_W'(k)) begin
                w_acc_next[lane_lsb(k, ELEM_W) +: ELEM_W] = in_data;
                w_keep_next[k] = 1'b1;
            end
        end
    end

    // Pop and reload may share an edge; the reload wins so no bubble appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_acc_keep  <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_acc_keep  <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_done) begin
                r_out_data  <= w_acc_next;
                r_out_keep  <= w_keep_next;
                r_out_last  <= in_last;
                r_out_valid <= 1'b1;
                r_idx       <= '0;
                r_acc       <= '0;
                r_acc_keep  <= '0;
            end else if (w_in_fire) begin
                r_acc       <= w_acc_next;
                r_acc_keep  <= w_keep_next;
                r_idx       <= r_idx + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

endmodule

// File: rtl/stream_unpack_core.sv
// Splits one wide word into up to NUM_ELEM narrow elements, lane 0 first.
// The element count comes from popcount(in_keep); zero-keep words vanish.
module stream_unpack_core
    import spatial_filter_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int NUM_ELEM = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEM_W*NUM_ELEM-1:0]   in_data,
    input  logic [NUM_ELEM-1:0]          in_keep,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ELEM_W-1:0]            out_data,
    output logic                         out_last
);

    localparam int CNT_W = clog2(NUM_ELEM);
    localparam int IN_W  = ELEM_W * NUM_ELEM;

    logic [IN_W-1:0]  r_buf;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W:0]   r_num;
    logic             r_last;
    logic             r_valid;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_final;
    logic [CNT_W:0]   w_pop;
    logic [ELEM_W-1:0] w_out_data;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            w_pop = w_pop + (CNT_W+1)'(in_keep[k]);
        end
    end

    always_comb begin
        w_out_data = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (r_pos == CNT_W'(k)) begin
                w_out_data = r_buf[lane_lsb(k, ELEM_W) +: ELEM_W];
            end
        end
    end

    assign w_final    = r_valid & ({1'b0, r_pos} == (r_num - (CNT_W+1)'(1)));
    assign w_out_fire = r_valid & out_ready;
    assign in_ready   = !r_valid | (w_final & out_ready);
    assign w_in_fire  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_pos   <= '0;
            r_num   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (clear) begin
            r_buf   <= '0;
            r_pos   <= '0;
            r_num   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_out_fire) begin
                if (w_final) begin
                    r_valid <= 1'b0;
                end else begin
                    r_pos <= r_pos + CNT_W'(1);
                end
            end
            if (w_in_fire) begin
                r_buf   <= in_data;
                r_pos   <= '0;
                r_num   <= w_pop;
                r_last  <= in_last;
                r_valid <= (w_pop != '0);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = w_out_data;
    assign out_last  = w_final & r_last;

endmodule

// File: rtl/stream_pack_unpack.sv
// Handshaked lane-width converter: PACK gathers, UNPACK splits.
// MODE picks the core at elaboration; the unused side is tied off here.
module stream_pack_unpack
    import spatial_filter_pkg::*;
#(
    parameter int  ELEM_W   = 8,
    parameter int  NUM_ELEM = 4,
    parameter int  MODE     = MODE_PACK,
    localparam int IN_W     = (MODE == MODE_PACK) ? ELEM_W : ELEM_W * NUM_ELEM,
    localparam int OUT_W    = (MODE == MODE_PACK) ? ELEM_W * NUM_ELEM : ELEM_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic [NUM_ELEM-1:0] in_keep,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [NUM_ELEM-1:0] out_keep,
    output logic                out_last
);

    if (ELEM_W < 1) begin : g_bad_elem_w
        $error("stream_pack_unpack: ELEM_W must be >= 1");
    end
    if (NUM_ELEM < 2) begin : g_bad_num_elem
        $error("stream_pack_unpack: NUM_ELEM must be >= 2");
    end
    if (MODE != MODE_PACK && MODE != MODE_UNPACK) begin : g_bad_mode
        $error("stream_pack_unpack: MODE must be 0 or 1");
    end

    if (MODE == MODE_PACK) begin : g_pack
        logic w_unused_keep;
        assign w_unused_keep = ^in_keep;

        stream_pack_core #(
            .ELEM_W   (ELEM_W),
            .NUM_ELEM (NUM_ELEM)
        ) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_last   (in_last),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_keep  (out_keep),
            .out_last  (out_last)
        );
    end else begin : g_unpack
        assign out_keep = '1;

        stream_unpack_core #(
            .ELEM_W   (ELEM_W),
            .NUM_ELEM (NUM_ELEM)
        ) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_keep   (in_keep),
            .in_last   (in_last),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_last  (out_last)
        );
    end

endmodule

// File: tb/tb_stream_pack_unpack.sv
// Directed bench for stream_pack_unpack: one PACK and one UNPACK instance.
// Scenario tasks drive vectors and compare against hand-computed values.
module tb_stream_pack_unpack;

    logic clk;
    logic rst_n;
    logic clear;

    logic        p_in_valid;
    logic        p_in_ready;
    logic [7:0]  p_in_data;
    logic [3:0]  p_in_keep;
    logic        p_in_last;
    logic        p_out_valid;
    logic        p_out_ready;
    logic [31:0] p_out_data;
    logic [3:0]  p_out_keep;
    logic        p_out_last;

    logic        u_in_valid;
    logic        u_in_ready;
    logic [31:0] u_in_data;
    logic [3:0]  u_in_keep;
    logic        u_in_last;
    logic        u_out_valid;
    logic        u_out_ready;
    logic [7:0]  u_out_data;
    logic [3:0]  u_out_keep;
    logic        u_out_last;

    int errors;
    int checks;

    stream_pack_unpack #(
        .ELEM_W   (8),
        .NUM_ELEM (4),
        .MODE     (0)
    ) u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_data   (p_in_data),
        .in_keep   (p_in_keep),
        .in_last   (p_in_last),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_data  (p_out_data),
        .out_keep  (p_out_keep),
        .out_last  (p_out_last)
    );

    stream_pack_unpack #(
        .ELEM_W   (8),
        .NUM_ELEM (4),
        .MODE     (1)
    ) u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (u_in_valid),
        .in_ready  (u_in_ready),
        .in_data   (u_in_data),
        .in_keep   (u_in_keep),
        .in_last   (u_in_last),
        .out_valid (u_out_valid),
        .out_ready (u_out_ready),
        .out_data  (u_out_data),
        .out_keep  (u_out_keep),
        .out_last  (u_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pbeat(input logic [7:0] d, input logic l);
        p_in_valid = 1'b1;
        p_in_data  = d;
        p_in_last  = l;
        step();
    endtask

    task automatic chk_pack(input string name, input logic v,
                            input logic [31:0] d, input logic [3:0] k,
                            input logic l);
        checks++;
        if (p_out_valid !== v || (v && (p_out_data !== d ||
            p_out_keep !== k || p_out_last !== l))) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h k=%b l=%b want v=%b d=%h k=%b l=%b",
                     name, p_out_valid, p_out_data, p_out_keep, p_out_last,
                     v, d, k, l);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        p_in_valid = 1'b0; p_in_data = '0; p_in_keep = '0; p_in_last = 1'b0;
        p_out_ready = 1'b1;
        u_in_valid = 1'b0; u_in_data = '0; u_in_keep = '0; u_in_last = 1'b0;
        u_out_ready = 1'b1;
        #12;
        checks++;
        if (p_out_valid !== 1'b0 || p_out_data !== 32'h0 ||
            p_out_keep !== 4'h0 || p_out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_pack_out: got v=%b d=%h k=%b l=%b want all zero",
                     p_out_valid, p_out_data, p_out_keep, p_out_last);
        end
        checks++;
        if (u_out_valid !== 1'b0 || u_out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_unpack_out: got v=%b l=%b want 0 0",
                     u_out_valid, u_out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (p_in_ready !== 1'b1 || u_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got p=%b u=%b want 1 1",
                     p_in_ready, u_in_ready);
        end
    endtask

    task automatic test_pack_full();
        p_out_ready = 1'b1;
        pbeat(8'h11, 1'b0);
        pbeat(8'h22, 1'b0);
        pbeat(8'h33, 1'b0);
        chk_pack("pack_full_not_yet", 1'b0, 32'h0, 4'h0, 1'b0);
        pbeat(8'h44, 1'b0);
        chk_pack("pack_full_word0", 1'b1, 32'h44332211, 4'b1111, 1'b0);
        pbeat(8'h55, 1'b0);
        chk_pack("pack_full_popped", 1'b0, 32'h0, 4'h0, 1'b0);
        pbeat(8'h66, 1'b0);
        pbeat(8'h77, 1'b0);
        pbeat(8'h88, 1'b0);
        chk_pack("pack_full_word1", 1'b1, 32'h88776655, 4'b1111, 1'b0);
    endtask

    task automatic test_pack_partial();
        pbeat(8'hAA, 1'b0);
        pbeat(8'hBB, 1'b1);
        chk_pack("pack_partial", 1'b1, 32'h0000BBAA, 4'b0011, 1'b1);
        pbeat(8'h01, 1'b1);
        chk_pack("pack_single_lane", 1'b1, 32'h00000001, 4'b0001, 1'b1);
        p_in_valid = 1'b0;
        p_in_last  = 1'b0;
        step();
        chk_pack("pack_drained", 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_pack_backpressure();
        p_out_ready = 1'b0;
        pbeat(8'h10, 1'b0);
        pbeat(8'h20, 1'b0);
        pbeat(8'h30, 1'b0);
        pbeat(8'h40, 1'b0);
        p_in_data = 8'h50;
        #1;
        checks++;
        if (p_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_low: got %b want 0", p_in_ready);
        end
        step();
        step();
        step();
        chk_pack("bp_held", 1'b1, 32'h40302010, 4'b1111, 1'b0);
        p_out_ready = 1'b1;
        #1;
        checks++;
        if (p_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_release: got %b want 1", p_in_ready);
        end
        step();
        chk_pack("bp_popped", 1'b0, 32'h0, 4'h0, 1'b0);
        pbeat(8'h60, 1'b0);
        pbeat(8'h70, 1'b0);
        pbeat(8'h80, 1'b0);
        chk_pack("bp_resume_word", 1'b1, 32'h80706050, 4'b1111, 1'b0);
        p_in_valid = 1'b0;
        step();
    endtask

    task automatic test_unpack_full();
        logic [7:0] exp_d [8];
        logic       exp_l [8];
        exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        u_out_ready = 1'b1;
        u_in_valid  = 1'b1;
        u_in_data   = 32'hDDCCBBAA;
        u_in_keep   = 4'b1111;
        u_in_last   = 1'b1;
        step();
        u_in_data = 32'h44332211;
        u_in_keep = 4'b1111;
        u_in_last = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (u_out_valid !== 1'b1 || u_out_data !== exp_d[i] ||
                u_out_last !== exp_l[i] || u_out_keep !== 4'b1111) begin
                errors++;
                $display("FAIL unpack_full_%0d: got v=%b d=%h l=%b k=%b want v=1 d=%h l=%b k=1111",
                         i, u_out_valid, u_out_data, u_out_last, u_out_keep,
                         exp_d[i], exp_l[i]);
            end
            if (i == 0 || i == 3) begin
                checks++;
                if (u_in_ready !== (i == 3)) begin
                    errors++;
                    $display("FAIL unpack_in_ready_%0d: got %b want %b",
                             i, u_in_ready, (i == 3));
                end
            end
            step();
            if (i == 3) u_in_valid = 1'b0;
        end
        checks++;
        if (u_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL unpack_full_end: got v=%b want 0", u_out_valid);
        end
    endtask

    task automatic test_unpack_partial();
        u_in_valid = 1'b1;
        u_in_data  = 32'h00002211;
        u_in_keep  = 4'b0011;
        u_in_last  = 1'b0;
        step();
        u_in_valid = 1'b0;
        checks++;
        if (u_out_valid !== 1'b1 || u_out_data !== 8'h11 || u_out_last !== 1'b0) begin
            errors++;
            $display("FAIL unpack_partial_0: got v=%b d=%h l=%b want 1 11 0",
                     u_out_valid, u_out_data, u_out_last);
        end
        step();
        checks++;
        if (u_out_valid !== 1'b1 || u_out_data !== 8'h22 || u_out_last !== 1'b0) begin
            errors++;
            $display("FAIL unpack_partial_1: got v=%b d=%h l=%b want 1 22 0",
                     u_out_valid, u_out_data, u_out_last);
        end
        step();
        checks++;
        if (u_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL unpack_partial_end: got v=%b want 0", u_out_valid);
        end
        u_in_valid = 1'b1;
        u_in_data  = 32'hFFFFFFFF;
        u_in_keep  = 4'b0000;
        u_in_last  = 1'b1;
        step();
        u_in_valid = 1'b0;
        u_in_last  = 1'b0;
        #1;
        checks++;
        if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL unpack_zero_keep: got v=%b rdy=%b want 0 1",
                     u_out_valid, u_in_ready);
        end
        step();
        checks++;
        if (u_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL unpack_zero_keep_late: got v=%b want 0", u_out_valid);
        end
    endtask

    task automatic test_clear();
        p_out_ready = 1'b1;
        pbeat(8'hA1, 1'b0);
        pbeat(8'hA2, 1'b0);
        p_in_data = 8'hA3;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_pack("clear_no_output", 1'b0, 32'h0, 4'h0, 1'b0);
        pbeat(8'hB1, 1'b0);
        pbeat(8'hB2, 1'b0);
        pbeat(8'hB3, 1'b0);
        pbeat(8'hB4, 1'b0);
        chk_pack("clear_clean_word", 1'b1, 32'hB4B3B2B1, 4'b1111, 1'b0);
        p_in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        u_out_ready = 1'b1;
        u_in_valid  = 1'b1;
        u_in_data   = 32'hDDCCBBAA;
        u_in_keep   = 4'b1111;
        u_in_last   = 1'b1;
        step();
        u_in_valid = 1'b0;
        step();
        checks++;
        if (u_out_valid !== 1'b1 || u_out_data !== 8'hBB) begin
            errors++;
            $display("FAIL arst_pre: got v=%b d=%h want 1 bb",
                     u_out_valid, u_out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_out_valid !== 1'b0 || u_out_data !== 8'h00 || u_out_last !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got v=%b d=%h l=%b want 0 00 0",
                     u_out_valid, u_out_data, u_out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_after: got rdy=%b v=%b want 1 0",
                     u_in_ready, u_out_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_pack_full();
        test_pack_partial();
        test_pack_backpressure();
        test_unpack_full();
        test_unpack_partial();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
